// File: rtl/layer_seq_ctrl.sv
// Per-layer sequencer: walks one encoder layer through seven engines with start/done pulses,
// tracks the layer index, a per-stage watchdog and the per-layer cycle count.
module layer_seq_ctrl #(
  parameter int NUM_LAYER      = 12,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CYC_W          = 24
)(
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         ln_start,
  input  logic                         abort,
  output logic                         ln1_start,
  input  logic                         ln1_done,
  output logic                         qkv_start,
  input  logic                         qkv_done,
  output logic                         attn_start,
  input  logic                         attn_done,
  output logic                         oproj_start,
  input  logic                         oproj_done,
  output logic                         ln2_start,
  input  logic                         ln2_done,
  output logic                         lin1_start,
  input  logic                         lin1_done,
  output logic                         lin2_start,
  input  logic                         lin2_done,
  output logic                         linear2_done,
  output logic                         busy,
  output logic [3:0]                   stage,
  output logic [$clog2(NUM_LAYER)-1:0] layer_idx,
  output logic [CYC_W-1:0]             layer_cycles,
  output logic [1:0]                   err
);

  localparam int IDX_W = $clog2(NUM_LAYER);
  localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_LN1 = 4'd1, S_QKV = 4'd2, S_ATTN = 4'd3, S_OPROJ = 4'd4,
    S_LN2 = 4'd5, S_LIN1 = 4'd6, S_LIN2 = 4'd7, S_ERR = 4'd8
  } state_t;

  state_t            state, state_nxt;
  logic [6:0]        start_q, start_d;
  logic              l2d_q, l2d_d, busy_q;
  logic [1:0]        err_q, err_d;
  logic [IDX_W-1:0]  idx_q;
  logic [CYC_W-1:0]  cyc_cnt, lc_q;
  logic [WD_W-1:0]   wd_cnt;
  logic [7:0]        done_vec;
  logic [2:0]        sidx;
  logic              cur_done, wd_hit, in_stage;

  // Stage states 1..7 map to done bits 0..6; bit 7 pads the IDLE wrap-around index.
  assign done_vec = {1'b0, lin2_done, lin1_done, ln2_done, oproj_done, attn_done, qkv_done, ln1_done};
  assign sidx     = state[2:0] - 3'd1;
  assign cur_done = done_vec[sidx];
  assign in_stage = (state != S_IDLE) && (state != S_ERR);
  assign wd_hit   = (TIMEOUT_CYCLES != 0) && (wd_cnt == WD_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Done beats the watchdog when both land in the same cycle.
  always_comb begin
    state_nxt = state;
    if (abort) state_nxt = S_IDLE;
    else begin
      case (state)
        S_IDLE:  if (ln_start) state_nxt = S_LN1;
        S_ERR:   state_nxt = S_ERR;
        default: begin
          if (cur_done)    state_nxt = (state == S_LIN2) ? S_IDLE : state_t'(state + 4'd1);
          else if (wd_hit) state_nxt = S_ERR;
        end
      endcase
    end
  end

  always_comb begin
    start_d = '0;
    if (state_nxt != state && state_nxt != S_IDLE && state_nxt != S_ERR)
      start_d[state_nxt[2:0] - 3'd1] = 1'b1;
    l2d_d = !abort && (state == S_LIN2) && (state_nxt == S_IDLE);
    err_d = err_q;
    if (abort) err_d = '0;
    else begin
      if (state != S_IDLE && ln_start)            err_d[1] = 1'b1;
      if (state_nxt == S_ERR && state != S_ERR)   err_d[0] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      start_q <= '0;
      l2d_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= '0;
      idx_q   <= '0;
      cyc_cnt <= '0;
      lc_q    <= '0;
      wd_cnt  <= '0;
    end else begin
      start_q <= start_d;
      l2d_q   <= l2d_d;
      busy_q  <= (state_nxt != S_IDLE);
      err_q   <= err_d;
      if (abort) begin
        idx_q   <= '0;
        cyc_cnt <= '0;
        wd_cnt  <= '0;
      end else begin
        wd_cnt <= (state_nxt != state || state_nxt == S_IDLE || state_nxt == S_ERR) ? '0 : wd_cnt + 1'b1;
        // Counter holds the number of in-layer cycles including the current one.
        if (state == S_IDLE && state_nxt == S_LN1) cyc_cnt <= CYC_W'(1);
        else if (in_stage && cyc_cnt != '1)        cyc_cnt <= cyc_cnt + 1'b1;
        if (l2d_d) begin
          idx_q <= (idx_q == IDX_W'(NUM_LAYER - 1)) ? '0 : idx_q + 1'b1;
          lc_q  <= cyc_cnt;
        end
      end
    end
  end

  assign {lin2_start, lin1_start, ln2_start, oproj_start, attn_start, qkv_start, ln1_start} = start_q;
  assign linear2_done = l2d_q;
  assign busy         = busy_q;
  assign stage        = state;
  assign layer_idx    = idx_q;
  assign layer_cycles = lc_q;
  assign err          = err_q;

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Randomized bench for layer_seq_ctrl: an engine responder answers start pulses after
// per-stage delays and a cycle-level model predicts every pulse time and status output.
module tb_layer_seq_ctrl;
  localparam int NL = 12;
  localparam int TO = 8;
  localparam int CW = 24;

  logic clk, rstn, ln_start, abort;
  logic [6:0] st_o, resp_done, stray_done, done_in;
  logic linear2_done, busy;
  logic [3:0] stage;
  logic [3:0] layer_idx;
  logic [CW-1:0] layer_cycles;
  logic [1:0] err;

  int errors = 0, checks = 0;
  int cyc = 0;
  int dly[7];
  int pend[7];
  int st_cyc[8];
  int pc[8];
  int m_idx = 0, m_lc = 0;

  assign done_in = resp_done | stray_done;

  layer_seq_ctrl #(.NUM_LAYER(NL), .TIMEOUT_CYCLES(TO), .CYC_W(CW)) dut (
    .clk(clk), .rstn(rstn), .ln_start(ln_start), .abort(abort),
    .ln1_start(st_o[0]),   .ln1_done(done_in[0]),
    .qkv_start(st_o[1]),   .qkv_done(done_in[1]),
    .attn_start(st_o[2]),  .attn_done(done_in[2]),
    .oproj_start(st_o[3]), .oproj_done(done_in[3]),
    .ln2_start(st_o[4]),   .ln2_done(done_in[4]),
    .lin1_start(st_o[5]),  .lin1_done(done_in[5]),
    .lin2_start(st_o[6]),  .lin2_done(done_in[6]),
    .linear2_done(linear2_done), .busy(busy), .stage(stage),
    .layer_idx(layer_idx), .layer_cycles(layer_cycles), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Engine responder: done is raised dly[k] cycles after start k is seen (-1 = never).
  initial begin
    resp_done = '0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 7; k++) begin
        resp_done[k] = 1'b0;
        if (pend[k] > 0) begin
          pend[k]--;
          if (pend[k] == 0) resp_done[k] = 1'b1;
        end
        if (st_o[k] === 1'b1) begin
          st_cyc[k] = cyc;
          pc[k]++;
          if (dly[k] == 0) resp_done[k] = 1'b1;
          else if (dly[k] > 0) pend[k] = dly[k];
        end
      end
      if (linear2_done === 1'b1) begin
        st_cyc[7] = cyc;
        pc[7]++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  // One layer; expected start of stage k is t0+1+sum_{j<k}(d[j]+1).
  task automatic run_layer(input int d[7], input int s_from, input int s_to,
                           input logic [6:0] s_mask, input int lnst_at,
                           input logic [1:0] exp_err, input string tag);
    int t0, s, n, pc7, got;
    int exp_st[7];
    for (int k = 0; k < 7; k++) dly[k] = d[k];
    @(negedge clk);
    t0 = cyc;
    pc7 = pc[7];
    ln_start = 1'b1;
    s = t0 + 1;
    for (int k = 0; k < 7; k++) begin
      exp_st[k] = s;
      s += d[k] + 1;
    end
    @(negedge clk);
    ln_start = 1'b0;
    n = 0;
    while (linear2_done !== 1'b1 && n < 400) begin
      stray_done = (cyc - t0 >= s_from && cyc - t0 <= s_to) ? s_mask : 7'd0;
      ln_start   = (cyc - t0 == lnst_at);
      @(negedge clk);
      n++;
    end
    stray_done = '0;
    ln_start = 1'b0;
    got = cyc;
    #1;
    m_idx = (m_idx + 1) % NL;
    m_lc  = s - t0 - 1;
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (st_cyc[k] != exp_st[k]) begin
        errors++;
        $display("FAIL %s start[%0d] cycle: got %0d want %0d", tag, k, st_cyc[k] - t0, exp_st[k] - t0);
      end
    end
    checks++;
    if (got != s) begin
      errors++;
      $display("FAIL %s linear2_done cycle: got %0d want %0d", tag, got - t0, s - t0);
    end
    checks++;
    if (pc[7] - pc7 != 1) begin
      errors++;
      $display("FAIL %s linear2_done count: got %0d want 1", tag, pc[7] - pc7);
    end
    checks++;
    if (layer_idx !== 4'(m_idx)) begin
      errors++;
      $display("FAIL %s layer_idx: got %0d want %0d", tag, layer_idx, m_idx);
    end
    checks++;
    if (layer_cycles !== CW'(m_lc)) begin
      errors++;
      $display("FAIL %s layer_cycles: got %0d want %0d", tag, layer_cycles, m_lc);
    end
    checks++;
    if (err !== exp_err || busy !== 1'b0 || stage !== 4'd0) begin
      errors++;
      $display("FAIL %s status: got err=%b busy=%b stage=%0d want err=%b busy=0 stage=0",
               tag, err, busy, stage, exp_err);
    end
  endtask

  task automatic pulse_abort();
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    m_idx = 0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; ln_start = 1'b0; abort = 1'b0; stray_done = '0;
    for (int k = 0; k < 7; k++) dly[k] = 3;
    repeat (3) @(negedge clk);
    checks++;
    if (st_o !== 7'd0 || linear2_done !== 1'b0 || busy !== 1'b0 || err !== 2'b00 ||
        layer_idx !== 4'd0 || layer_cycles !== '0 || stage !== 4'd0) begin
      errors++;
      $display("FAIL reset: got st=%b l2d=%b busy=%b err=%b idx=%0d lc=%0d stage=%0d want all 0",
               st_o, linear2_done, busy, err, layer_idx, layer_cycles, stage);
    end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_nominal();
    int d[7];
    for (int k = 0; k < 7; k++) d[k] = 3;
    run_layer(d, -1, -1, 7'd0, -1, 2'b00, "nominal");
    checks++;
    if (layer_cycles !== 24'd28 || layer_idx !== 4'd1) begin
      errors++;
      $display("FAIL nominal_fixed: got lc=%0d idx=%0d want lc=28 idx=1", layer_cycles, layer_idx);
    end
  endtask

  task automatic test_full_model();
    int d[7];
    int pc7;
    pulse_abort();
    pc7 = pc[7];
    for (int l = 0; l < NL; l++) begin
      for (int k = 0; k < 7; k++) d[k] = $urandom_range(0, 6);
      run_layer(d, -1, -1, 7'd0, -1, 2'b00, "full_model");
    end
    checks++;
    if (pc[7] - pc7 != NL || layer_idx !== 4'd0 || err !== 2'b00) begin
      errors++;
      $display("FAIL full_model_end: got pulses=%0d idx=%0d err=%b want pulses=%0d idx=0 err=00",
               pc[7] - pc7, layer_idx, err, NL);
    end
  endtask

  task automatic test_stray();
    int d[7];
    for (int k = 0; k < 7; k++) d[k] = 3;
    d[0] = 5;
    run_layer(d, 2, 3, 7'b1000010, -1, 2'b00, "stray_in_ln1");
    d[0] = 0;
    run_layer(d, -1, -1, 7'd0, -1, 2'b00, "ln1_done_with_start");
  endtask

  task automatic test_done_at_limit();
    int d[7];
    for (int k = 0; k < 7; k++) d[k] = (k % 2 == 0) ? TO : 0;
    run_layer(d, -1, -1, 7'd0, -1, 2'b00, "done_at_limit");
  endtask

  task automatic test_random();
    int d[7];
    for (int l = 0; l < 4; l++) begin
      for (int k = 0; k < 7; k++) d[k] = $urandom_range(0, TO);
      run_layer(d, -1, -1, 7'd0, -1, 2'b00, "random");
    end
  endtask

  task automatic test_protocol();
    int d[7];
    for (int k = 0; k < 7; k++) d[k] = 3;
    run_layer(d, -1, -1, 7'd0, 22, 2'b10, "protocol");
  endtask

  task automatic test_abort();
    int d[7];
    int t0, pc7, pc4;
    for (int k = 0; k < 7; k++) begin
      d[k] = 3;
      dly[k] = 3;
    end
    @(negedge clk);
    t0 = cyc;
    ln_start = 1'b1;
    @(negedge clk);
    ln_start = 1'b0;
    while (cyc < t0 + 14) @(negedge clk);
    checks++;
    if (stage !== 4'd4) begin
      errors++;
      $display("FAIL abort_pre_stage: got %0d want 4", stage);
    end
    pc7 = pc[7];
    pc4 = pc[4];
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    m_idx = 0;
    checks++;
    if (stage !== 4'd0 || busy !== 1'b0 || err !== 2'b00 || layer_idx !== 4'd0 ||
        st_o !== 7'd0 || layer_cycles !== CW'(m_lc)) begin
      errors++;
      $display("FAIL abort_state: got stage=%0d busy=%b err=%b idx=%0d st=%b lc=%0d want 0/0/00/0/0/%0d",
               stage, busy, err, layer_idx, st_o, layer_cycles, m_lc);
    end
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (pc[7] != pc7 || pc[4] != pc4 || stage !== 4'd0) begin
      errors++;
      $display("FAIL abort_quiet: got l2d=%0d ln2=%0d stage=%0d want l2d=%0d ln2=%0d stage=0",
               pc[7] - pc7 + pc7, pc[4], stage, pc7, pc4);
    end
  endtask

  task automatic test_watchdog();
    int t0, n, exp_err_cyc, pc3;
    for (int k = 0; k < 7; k++) dly[k] = 3;
    dly[2] = -1;
    @(negedge clk);
    t0 = cyc;
    ln_start = 1'b1;
    @(negedge clk);
    ln_start = 1'b0;
    exp_err_cyc = t0 + 9 + TO + 1;
    n = 0;
    while (stage !== 4'd8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cyc != exp_err_cyc) begin
      errors++;
      $display("FAIL watchdog_cycle: got %0d want %0d", cyc - t0, exp_err_cyc - t0);
    end
    checks++;
    if (err !== 2'b01 || busy !== 1'b1) begin
      errors++;
      $display("FAIL watchdog_flags: got err=%b busy=%b want err=01 busy=1", err, busy);
    end
    #1;
    pc3 = pc[3];
    stray_done = 7'b0000101;
    repeat (2) @(negedge clk);
    stray_done = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (stage !== 4'd8 || pc[3] != pc3 || st_o !== 7'd0 || err !== 2'b01) begin
      errors++;
      $display("FAIL watchdog_hold: got stage=%0d oproj=%0d err=%b want stage=8 oproj=%0d err=01",
               stage, pc[3], err, pc3);
    end
    @(negedge clk);
    ln_start = 1'b1;
    @(negedge clk);
    ln_start = 1'b0;
    checks++;
    if (err !== 2'b11 || stage !== 4'd8) begin
      errors++;
      $display("FAIL err_ln_start: got err=%b stage=%0d want err=11 stage=8", err, stage);
    end
    pulse_abort();
    checks++;
    if (stage !== 4'd0 || err !== 2'b00 || layer_idx !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL watchdog_abort: got stage=%0d err=%b idx=%0d busy=%b want 0/00/0/0",
               stage, err, layer_idx, busy);
    end
    for (int k = 0; k < 7; k++) dly[k] = 3;
  endtask

  task automatic test_reset_mid();
    int d[7];
    int t0;
    for (int k = 0; k < 7; k++) d[k] = 2;
    run_layer(d, -1, -1, 7'd0, -1, 2'b00, "pre_reset");
    for (int k = 0; k < 7; k++) dly[k] = 3;
    @(negedge clk);
    t0 = cyc;
    ln_start = 1'b1;
    @(negedge clk);
    ln_start = 1'b0;
    while (cyc < t0 + 18) @(negedge clk);
    checks++;
    if (stage !== 4'd5) begin
      errors++;
      $display("FAIL reset_mid_pre_stage: got %0d want 5", stage);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if (st_o !== 7'd0 || linear2_done !== 1'b0 || busy !== 1'b0 || err !== 2'b00 ||
        layer_idx !== 4'd0 || layer_cycles !== '0 || stage !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid: got st=%b l2d=%b busy=%b err=%b idx=%0d lc=%0d stage=%0d want all 0",
               st_o, linear2_done, busy, err, layer_idx, layer_cycles, stage);
    end
    @(negedge clk);
    rstn = 1'b1;
    m_idx = 0;
    m_lc = 0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_full_model();
    test_stray();
    test_done_at_limit();
    test_random();
    test_protocol();
    test_abort();
    test_watchdog();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
